// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared UART RX constants and FSM state encoding.
//            PARITY state exists only when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DataBits   = 8;
  localparam int MinBaudDiv = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Fall-through RX FIFO; a pop frees room for a same-cycle push,
//            clear has priority over push and pop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int Depth = 8,
  parameter int Width = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(Depth):0]   o_fill,
  output logic                     o_drop
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_fill;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_fill == (PtrW+1)'(Depth));
  assign w_empty = (r_fill == '0);
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  // When full, an effective pop is exactly i_pop.
  assign o_drop  = i_push & w_full & ~i_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_fill <= r_fill + 1'b1;
      else if (!w_push && w_pop) r_fill <= r_fill - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = ~w_empty;
  assign o_fill  = r_fill;

endmodule
`default_nettype wire

// File: rtl/uart_rx_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_buf
// Brief    : UART receiver (8 data bits, LSB first, 1 stop) feeding an RX FIFO.
//            Define UART_RX_PARITY_EN to add a parity bit and parity_err_o.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int Depth = 8,
  parameter int DivW  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_en_i,
  input  logic [DivW-1:0]        baud_div_i,
  input  logic                   rx_i,
  output logic [DataBits-1:0]    data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [$clog2(Depth):0] fill_o,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  input  logic                   clear_i
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                   parity_odd_i,
  output logic                   parity_err_o
`endif
);

  localparam int BitW = $clog2(DataBits);

  logic                r_rx_meta;
  logic                r_rxs;
  logic                r_rxs_d;
  rx_state_e           r_state;
  rx_state_e           w_state_nxt;
  logic [DivW-1:0]     r_cnt;
  logic [DivW-1:0]     w_div;
  logic [DivW-1:0]     w_half;
  logic [BitW-1:0]     r_bit;
  logic [DataBits-1:0] r_shift;
  logic [DataBits-1:0] r_push_data;
  logic                r_push;
  logic                r_frame_err;
  logic                r_overrun;
  logic                w_tick_half;
  logic                w_tick_full;
  logic                w_cnt_clr;
  logic                w_shift_en;
  logic                w_stop_good;
  logic                w_stop_bad;
  logic                w_par_bad;
  logic                w_drop;
`ifdef UART_RX_PARITY_EN
  logic                w_par_en;
  logic                r_par_bad;
  logic                r_parity_err;
`endif

  // Out-of-range divisors are clamped so the half-bit count never underflows.
  assign w_div       = (baud_div_i < DivW'(MinBaudDiv)) ? DivW'(MinBaudDiv) : baud_div_i;
  assign w_half      = w_div >> 1;
  assign w_tick_half = (r_cnt == w_half - 1'b1);
  assign w_tick_full = (r_cnt == w_div - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en    = 1'b0;
`endif
    case (r_state)
      // A true 1->0 edge is required, so a low line left by a bad stop bit
      // cannot start a frame until it has returned high.
      IDLE: begin
        if (r_rxs_d && !r_rxs) begin
          w_state_nxt = START;
          w_cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (w_tick_half) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = r_rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick_full) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit == BitW'(DataBits - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_tick_full) begin
          w_cnt_clr   = 1'b1;
          w_par_en    = 1'b1;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_tick_full) begin
          w_cnt_clr   = 1'b1;
          w_stop_good = r_rxs;
          w_stop_bad  = ~r_rxs;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (!rx_en_i || clear_i) begin
      w_state_nxt = IDLE;
      w_shift_en  = 1'b0;
      w_stop_good = 1'b0;
      w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_en    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_cnt <= (w_cnt_clr || r_state == IDLE) ? '0 : r_cnt + 1'b1;
      if (r_state != DATA) r_bit <= '0;
      else if (w_shift_en) r_bit <= r_bit + 1'b1;
      if (w_shift_en)  r_shift     <= {r_rxs, r_shift[DataBits-1:1]};
      if (w_stop_good) r_push_data <= r_shift;
      r_push      <= w_stop_good & ~w_par_bad;
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_drop & ~clear_i;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_en) r_par_bad <= ((^r_shift) ^ r_rxs) != parity_odd_i;
      r_parity_err <= (w_stop_good | w_stop_bad) & r_par_bad;
    end
  end
  assign w_par_bad    = r_par_bad;
  assign parity_err_o = r_parity_err;
`else
  assign w_par_bad = 1'b0;
`endif

  uart_rx_fifo #(
    .Depth (Depth),
    .Width (DataBits)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (clear_i),
    .i_push      (r_push),
    .i_push_data (r_push_data),
    .i_pop       (ready_i),
    .o_data      (data_o),
    .o_valid     (valid_o),
    .o_fill      (fill_o),
    .o_drop      (w_drop)
  );

  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule
`default_nettype wire
